// File: rtl/wake_arbiter_pkg.sv
// =============================================================================
// Module   : wake_arbiter_pkg
// Purpose  : State encoding and sizing helper shared by the wake arbiter.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

package wake_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_SLEEP  = 2'd0,
        ST_WAKE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_LINGER = 2'd3
    } state_t;

    // Ceiling log2; only ever evaluated on elaboration-time constants.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wake_arbiter_rr_pick.sv
// =============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin pick: first set req bit at or after ptr.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    // Two passes: indices at/above ptr first, then the wrapped-around lower part.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (PW'(i) >= ptr)) begin
                any       = 1'b1;
                idx       = PW'(i);
                onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                any       = 1'b1;
                idx       = PW'(i);
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wake_arbiter.sv
// =============================================================================
// Module   : wake_arbiter
// Purpose  : Sequences a gated resource enable (wake latency, linger hold)
//            and round-robin grants it among N requesters.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module wake_arbiter
    import wake_arbiter_pkg::*;
#(
    parameter int N    = 4,
    parameter int WAKE = 5,
    parameter int HOLD = 8
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         en,
    output logic         ready,
    output logic [1:0]   state
);

    localparam int c_ptr_w = clog2(N);
    localparam int c_cnt_w = clog2((WAKE > HOLD) ? WAKE : HOLD) + 1;
    localparam logic [c_cnt_w-1:0] c_wake_load = c_cnt_w'(WAKE - 1);
    localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD - 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_ptr_w-1:0]   r_ptr;

    logic [N-1:0]         w_onehot;
    logic [c_ptr_w-1:0]   w_idx;
    logic                 w_any;
    logic [c_ptr_w-1:0]   w_next_ptr;

    rr_pick #(
        .N  (N),
        .PW (c_ptr_w)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .onehot (w_onehot),
        .idx    (w_idx),
        .any    (w_any)
    );

    assign w_next_ptr = (w_idx == c_ptr_w'(N - 1)) ? '0 : (w_idx + c_ptr_w'(1));
    assign state      = r_state;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_SLEEP;
            r_cnt   <= '0;
            r_ptr   <= '0;
            grant   <= '0;
            en      <= 1'b0;
            ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_SLEEP: begin
                    if (w_any) begin
                        r_state <= ST_WAKE;
                        en      <= 1'b1;
                        r_cnt   <= c_wake_load;
                    end
                end
                ST_WAKE: begin
                    // Wakeup always completes, even if every request has gone away.
                    if (r_cnt == '0) begin
                        ready <= 1'b1;
                        if (w_any) begin
                            r_state <= ST_ACTIVE;
                            grant   <= w_onehot;
                            r_ptr   <= w_next_ptr;
                        end else begin
                            r_state <= ST_LINGER;
                            r_cnt   <= c_hold_load;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    // Owner keeps the grant until its own req drops.
                    if ((req & grant) == '0) begin
                        if (w_any) begin
                            grant <= w_onehot;
                            r_ptr <= w_next_ptr;
                        end else begin
                            grant   <= '0;
                            r_state <= ST_LINGER;
                            r_cnt   <= c_hold_load;
                        end
                    end
                end
                ST_LINGER: begin
                    if (w_any) begin
                        r_state <= ST_ACTIVE;
                        grant   <= w_onehot;
                        r_ptr   <= w_next_ptr;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_SLEEP;
                        en      <= 1'b0;
                        ready   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_SLEEP;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wake_arbiter.sv
// =============================================================================
// Module   : tb_wake_arbiter
// Purpose  : Directed self-checking bench for wake_arbiter (N=4, WAKE=5, HOLD=8).
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_wake_arbiter;

    logic       clk;
    logic       nreset;
    logic [3:0] req;
    logic [3:0] grant;
    logic       en;
    logic       ready;
    logic [1:0] state;

    int n_checks;
    int n_fail;

    wake_arbiter #(
        .N    (4),
        .WAKE (5),
        .HOLD (8)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .req    (req),
        .grant  (grant),
        .en     (en),
        .ready  (ready),
        .state  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; results are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] st, input logic e,
                                 input logic r, input logic [3:0] g);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".en"},    32'(en),    32'(e));
        check({tag, ".ready"}, 32'(ready), 32'(r));
        check({tag, ".grant"}, 32'(grant), 32'(g));
    endtask

    initial begin
        logic [3:0] exp_g;
        n_checks = 0;
        n_fail   = 0;
        nreset   = 1'b0;
        req      = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 2'd0, 1'b0, 1'b0, 4'b0000);
        nreset = 1'b1;

        // Wake timing: en at edge 1, ready/grant at edge 6.
        req = 4'b0001;
        tick();
        check_outputs("wake_e1", 2'd1, 1'b1, 1'b0, 4'b0000);
        repeat (4) tick();
        check_outputs("wake_e5", 2'd1, 1'b1, 1'b0, 4'b0000);
        tick();
        check_outputs("wake_e6", 2'd2, 1'b1, 1'b1, 4'b0001);
        tick();
        check("hold_e7.grant", 32'(grant), 32'h1);
        tick();
        check("hold_e8.grant", 32'(grant), 32'h1);

        // Round-robin handoff with zero idle cycles.
        req = 4'b1111;
        tick();
        check("rr_hold0.grant", 32'(grant), 32'h1);
        for (int o = 0; o < 4; o++) begin
            req   = 4'b1111 & ~(4'b0001 << o);
            exp_g = 4'b0001 << ((o + 1) % 4);
            tick();
            check($sformatf("rr_pass%0d.grant", o), 32'(grant), 32'(exp_g));
            check($sformatf("rr_pass%0d.state", o), 32'(state), 32'd2);
            req = 4'b1111;
            tick();
            check($sformatf("rr_keep%0d.grant", o), 32'(grant), 32'(exp_g));
        end

        // Linger then sleep: owner 0 drops, nobody else asks.
        req = 4'b0000;
        tick();
        check_outputs("linger_E", 2'd3, 1'b1, 1'b1, 4'b0000);
        repeat (7) tick();
        check_outputs("linger_E7", 2'd3, 1'b1, 1'b1, 4'b0000);
        tick();
        check_outputs("sleep_E8", 2'd0, 1'b0, 1'b0, 4'b0000);

        // Linger re-hit. Pointer is 1 here, only req0 asks -> grant 0001.
        req = 4'b0001;
        repeat (6) tick();
        check_outputs("rewake_e6", 2'd2, 1'b1, 1'b1, 4'b0001);
        req = 4'b0000;
        tick();
        check("rehit_linger.state", 32'(state), 32'd3);
        repeat (4) tick();
        check_outputs("rehit_cnt3", 2'd3, 1'b1, 1'b1, 4'b0000);
        req = 4'b0100;
        tick();
        check_outputs("rehit_grant", 2'd2, 1'b1, 1'b1, 4'b0100);

        // Async reset between edges while requester 2 owns the resource.
        #2;
        nreset = 1'b0;
        #1;
        check_outputs("async_rst", 2'd0, 1'b0, 1'b0, 4'b0000);
        req = 4'b1001;
        #1;
        nreset = 1'b1;
        // Pointer must restart at 0: 1001 picks requester 0, not 3.
        repeat (6) tick();
        check_outputs("post_rst_e6", 2'd2, 1'b1, 1'b1, 4'b0001);

        // Drain to sleep.
        req = 4'b0000;
        repeat (9) tick();
        check("drain.state", 32'(state), 32'd0);

        // Wake abort attempt: one-cycle pulse still runs the full wakeup.
        req = 4'b0010;
        tick();
        check("abort_e1.en", 32'(en), 32'd1);
        req = 4'b0000;
        repeat (5) tick();
        check_outputs("abort_e6", 2'd3, 1'b1, 1'b1, 4'b0000);
        repeat (7) tick();
        check("abort_e13.en", 32'(en), 32'd1);
        tick();
        check_outputs("abort_e14", 2'd0, 1'b0, 1'b0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Invariants checked on every falling edge while out of reset.
    always @(negedge clk) begin
        if (nreset) begin
            if (((grant & (grant - 4'd1)) != 4'd0) || ((grant != 4'd0) && !ready) ||
                (ready && !en) || ((grant != 4'd0) && (state != 2'd2))) begin
                check("invariant", {20'd0, grant, 2'd0, state, 2'd0, ready, en}, 32'hFFFF_FFFF);
            end
        end
    end

endmodule

`default_nettype wire
